// File: rtl/thor2025_wb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// A result carries its target register, byte enables and data.
package thor2025_wb_pkg;

    localparam int NWPORTS = 3;
    localparam int WB_WID  = 64;
    localparam int WB_RBIT = 11;

    typedef struct packed {
        logic [WB_RBIT:0]  tag;
        logic [7:0]        we;
        logic [WB_WID-1:0] data;
    } wb_result_t;

    // Source index visited at scan position off when the scan starts at base.
    function automatic int rot_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/thor2025_wb_fifo.sv
// Per-source result FIFO with a registered count; the head is readable in the
// cycle after the push, with no bypass from the input.
module thor2025_wb_fifo #(
    parameter int W     = 84,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign head    = mem[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= wdata;
    end

endmodule

// File: rtl/thor2025_regfile_wb_arb.sv
// Writeback arbiter: buffers results from NSRC units and issues up to three
// results with distinct target registers per cycle to the register file.
module thor2025_regfile_wb_arb
    import thor2025_wb_pkg::*;
#(
    parameter int NSRC  = 6,
    parameter int WID   = WB_WID,
    parameter int RBIT  = WB_RBIT,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NSRC-1:0]           src_valid,
    output logic [NSRC-1:0]           src_ready,
    input  logic [NSRC-1:0][RBIT:0]   src_tag,
    input  logic [NSRC-1:0][7:0]      src_we,
    input  logic [NSRC-1:0][WID-1:0]  src_data,
    output logic                      wr0,
    output logic                      wr1,
    output logic                      wr2,
    output logic [7:0]                we0,
    output logic [7:0]                we1,
    output logic [7:0]                we2,
    output logic [RBIT:0]             wa0,
    output logic [RBIT:0]             wa1,
    output logic [RBIT:0]             wa2,
    output logic [WID-1:0]            i0,
    output logic [WID-1:0]            i1,
    output logic [WID-1:0]            i2
);

    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int RW = $bits(wb_result_t);

    logic [NSRC-1:0]              full;
    logic [NSRC-1:0]              empty;
    logic [NSRC-1:0]              push;
    logic [NSRC-1:0]              pop;
    wb_result_t [NSRC-1:0]        head;
    wb_result_t [NWPORTS-1:0]     grant_res;
    logic [NWPORTS-1:0]           grant_vld;
    logic [1:0]                   ngrant;
    logic [SW-1:0]                last_idx;
    logic [SW-1:0]                rr_ptr_reg;
    logic [SW-1:0]                rr_ptr_next;

    assign src_ready = rst ? ~full : '0;
    assign push      = src_valid & src_ready;

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        wb_result_t in_res;
        assign in_res = '{tag: src_tag[gi], we: src_we[gi], data: src_data[gi]};

        thor2025_wb_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[gi]),
            .wdata (in_res),
            .pop   (pop[gi]),
            .head  (head[gi]),
            .full  (full[gi]),
            .empty (empty[gi])
        );
    end

    // Rotating scan; a head whose tag matches an earlier grant waits a cycle,
    // which also keeps same-source order since only heads are considered.
    always_comb begin
        logic [SW-1:0] idx;
        logic          clash;
        idx       = '0;
        clash     = 1'b0;
        pop       = '0;
        grant_vld = '0;
        grant_res = '0;
        ngrant    = '0;
        last_idx  = rr_ptr_reg;
        for (int i = 0; i < NSRC; i++) begin
            idx   = SW'(rot_idx(int'(rr_ptr_reg), i, NSRC));
            clash = 1'b0;
            for (int j = 0; j < NWPORTS; j++) begin
                if (grant_vld[j] && grant_res[j].tag == head[idx].tag) clash = 1'b1;
            end
            if (!empty[idx] && !clash && ngrant != 2'(NWPORTS)) begin
                pop[idx]          = 1'b1;
                grant_vld[ngrant] = 1'b1;
                grant_res[ngrant] = head[idx];
                ngrant            = ngrant + 2'd1;
                last_idx          = idx;
            end
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (ngrant != '0) begin
            rr_ptr_next = (last_idx == SW'(NSRC - 1)) ? '0 : last_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) rr_ptr_reg <= '0;
        else      rr_ptr_reg <= rr_ptr_next;
    end

    logic           wr_reg [NWPORTS];
    logic [7:0]     we_reg [NWPORTS];
    logic [RBIT:0]  wa_reg [NWPORTS];
    logic [WID-1:0] i_reg  [NWPORTS];

    // Address/data/enables hold while the strobe is low.
    for (genvar gi = 0; gi < NWPORTS; gi++) begin : g_port
        always_ff @(posedge clk) begin
            if (!rst) begin
                wr_reg[gi] <= 1'b0;
                we_reg[gi] <= '0;
                wa_reg[gi] <= '0;
                i_reg[gi]  <= '0;
            end else begin
                wr_reg[gi] <= grant_vld[gi];
                if (grant_vld[gi]) begin
                    we_reg[gi] <= grant_res[gi].we;
                    wa_reg[gi] <= grant_res[gi].tag;
                    i_reg[gi]  <= grant_res[gi].data;
                end
            end
        end
    end

    assign wr0 = wr_reg[0];
    assign wr1 = wr_reg[1];
    assign wr2 = wr_reg[2];
    assign we0 = we_reg[0];
    assign we1 = we_reg[1];
    assign we2 = we_reg[2];
    assign wa0 = wa_reg[0];
    assign wa1 = wa_reg[1];
    assign wa2 = wa_reg[2];
    assign i0  = i_reg[0];
    assign i1  = i_reg[1];
    assign i2  = i_reg[2];

endmodule
